// File: rtl/core8_oci_trace_buffer.sv
// -----------------------------------------------------------------------------
// core8_oci_trace_buffer
//
// Capture buffer for the Nios II OCI data/control trace (DCT) stream. Each
// accepted trace word {dct_count, dct_buffer} is stored in a circular buffer
// and drained through a show-ahead valid/ready read port. An end-of-test
// request stops capture. The remaining entries then drain, and the block
// reports test_has_ended once the buffer is empty.
//
// Parameters:
//   DATA_W    width of dct_buffer
//   CNT_W     width of dct_count
//   DEPTH     number of entries (power of two, >= 2)
//   WRAP_MODE 0 = drop new words when full, 1 = overwrite the oldest entry
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   dct_buffer     in   trace payload
//   dct_count      in   number of valid slots in dct_buffer
//   dct_valid      in   capture strobe, one word per cycle
//   test_ending    in   end-of-test request (level or pulse)
//   rd_ready       in   consumer accepts the head entry
//   rd_valid       out  buffer non-empty (registered)
//   rd_data        out  head entry {[ts], dct_count, dct_buffer}
//   fill_level     out  number of stored entries (registered)
//   overflow       out  sticky: a word was dropped or overwritten
//   test_has_ended out  drain complete (registered)
//
// Build option:
//   CORE8_OCI_TRACE_TIMESTAMP_EN  when defined, a free-running 16-bit cycle
//   counter is sampled on each push and stored in the top 16 bits of the
//   entry, widening rd_data by 16 bits.
// -----------------------------------------------------------------------------
module core8_oci_trace_buffer #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
`ifdef CORE8_OCI_TRACE_TIMESTAMP_EN
  localparam int TS_W     = 16
`else
  localparam int TS_W     = 0
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             dct_buffer,
  input  logic [CNT_W-1:0]              dct_count,
  input  logic                          dct_valid,
  input  logic                          test_ending,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [TS_W+CNT_W+DATA_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]        fill_level,
  output logic                          overflow,
  output logic                          test_has_ended
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = TS_W + CNT_W + DATA_W;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_ENDED   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_fill;
  logic            r_rd_valid;
  logic            r_overflow;
  logic            r_ended;
  logic [EW-1:0]   r_mem [DEPTH];

  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [PW-1:0]   w_fill_nxt;
  logic            w_push_req;
  logic            w_pop;
  logic            w_full;
  logic            w_wr_en;
  logic            w_ovf_evt;
  logic [EW-1:0]   w_wr_entry;

  // Only CAPTURE accepts new words; pops follow the registered rd_valid, so
  // an empty buffer never pops even if a push lands in the same cycle.
  assign w_push_req = dct_valid && (r_state == ST_CAPTURE);
  assign w_pop      = r_rd_valid && rd_ready;
  assign w_full     = (r_fill == PW'(DEPTH));

`ifdef CORE8_OCI_TRACE_TIMESTAMP_EN
  logic [15:0] r_ts;

  // Free-running cycle counter sampled into each pushed entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts <= 16'd0;
    end else begin
      r_ts <= r_ts + 16'd1;
    end
  end

  assign w_wr_entry = {r_ts, dct_count, dct_buffer};
`else
  assign w_wr_entry = {dct_count, dct_buffer};
`endif

  // Pointer update: push/pop arbitration including the full-buffer policy.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_en      = 1'b0;
    w_ovf_evt    = 1'b0;

    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end

    if (w_push_req) begin
      if (!w_full || w_pop) begin
        // A simultaneous pop frees a slot, so a full buffer still takes the
        // word without loss.
        w_wr_en      = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      end else if (WRAP_MODE != 0) begin
        // Overwrite: the write slot aliases the oldest entry, which is
        // retired by advancing the read pointer alongside.
        w_wr_en      = 1'b1;
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
        w_ovf_evt    = 1'b1;
      end else begin
        w_ovf_evt    = 1'b1;
      end
    end else begin
      w_wr_en = 1'b0;
    end
  end

  assign w_fill_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;

  // Next-state logic for the capture / drain / ended sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CAPTURE: begin
        if (test_ending) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_DRAIN: begin
        if (w_fill_nxt == PW'(0)) begin
          w_state_nxt = ST_ENDED;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_ENDED: begin
        w_state_nxt = ST_ENDED;
      end
      default: begin
        w_state_nxt = ST_CAPTURE;
      end
    endcase
  end

  // Control registers: pointers, FSM state and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CAPTURE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill     <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_ended    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_fill     <= w_fill_nxt;
      r_rd_valid <= (w_fill_nxt != PW'(0));
      r_overflow <= r_overflow | w_ovf_evt;
      r_ended    <= (w_state_nxt == ST_ENDED);
    end
  end

  // Entry storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wr_entry;
    end
  end

  assign rd_data        = r_mem[r_rd_ptr[AW-1:0]];
  assign rd_valid       = r_rd_valid;
  assign fill_level     = r_fill;
  assign overflow       = r_overflow;
  assign test_has_ended = r_ended;

endmodule

// File: tb/tb_core8_oci_trace_buffer.sv
module tb_core8_oci_trace_buffer;

  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int LW     = CNT_W + DATA_W;
`ifdef CORE8_OCI_TRACE_TIMESTAMP_EN
  localparam int EW     = LW + 16;
`else
  localparam int EW     = LW;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [CNT_W-1:0]  dct_count = '0;
  logic              dct_valid = 1'b0;
  logic              test_ending = 1'b0;
  logic              rd_ready = 1'b0;

  logic              rv0, rv1, ov0, ov1, te0, te1;
  logic [EW-1:0]     rd0, rd1;
  logic [2:0]        fl0, fl1;

  int tests = 0;
  int fails = 0;

  // Reference model: one queue per instance, 0 = WRAP_MODE 0, 1 = WRAP_MODE 1.
  logic [EW-1:0] mq [2][$];
  bit            mov [2];
  int            mst [2];   // 0 capture, 1 drain, 2 ended
  int            ts_cnt;

  always #5 clk = ~clk;

  core8_oci_trace_buffer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .rd_ready(rd_ready),
    .rd_valid(rv0), .rd_data(rd0), .fill_level(fl0), .overflow(ov0), .test_has_ended(te0)
  );

  core8_oci_trace_buffer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .rd_ready(rd_ready),
    .rd_valid(rv1), .rd_data(rd1), .fill_level(fl1), .overflow(ov1), .test_has_ended(te1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mov[m] = 1'b0;
      mst[m] = 0;
    end
    ts_cnt = 0;
  endtask

  // Apply one clock edge worth of behaviour to the model.
  task automatic model_step();
    logic [EW-1:0] entry;
    bit            pop;
    bit            push;
`ifdef CORE8_OCI_TRACE_TIMESTAMP_EN
    entry = {ts_cnt[15:0], dct_count, dct_buffer};
`else
    entry = {dct_count, dct_buffer};
`endif
    for (int m = 0; m < 2; m++) begin
      pop  = (mq[m].size() > 0) && rd_ready;
      push = dct_valid && (mst[m] == 0);
      if (pop) void'(mq[m].pop_front());
      if (push) begin
        if (mq[m].size() < DEPTH) begin
          mq[m].push_back(entry);
        end else begin
          mov[m] = 1'b1;
          if (m == 1) begin
            void'(mq[m].pop_front());
            mq[m].push_back(entry);
          end
        end
      end
      if (mst[m] == 0 && test_ending) mst[m] = 1;
      else if (mst[m] == 1 && mq[m].size() == 0) mst[m] = 2;
    end
    ts_cnt = (ts_cnt + 1) % 65536;
  endtask

  task automatic cmp_one(input string tag, input int m, input logic rv, input logic [EW-1:0] rd,
                         input logic [2:0] fl, input logic ov, input logic te);
    chk({tag, "_rd_valid"}, 64'(rv), 64'(mq[m].size() > 0));
    chk({tag, "_fill"}, 64'(fl), 64'(mq[m].size()));
    chk({tag, "_overflow"}, 64'(ov), 64'(mov[m]));
    chk({tag, "_ended"}, 64'(te), 64'(mst[m] == 2));
    if (mq[m].size() > 0) chk({tag, "_rd_data"}, 64'(rd), 64'(mq[m][0]));
  endtask

  task automatic compare();
    cmp_one("w0", 0, rv0, rd0, fl0, ov0, te0);
    cmp_one("w1", 1, rv1, rd1, fl1, ov1, te1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dct_valid = 1'b0;
    test_ending = 1'b0;
    rd_ready = 1'b0;
    #1;
    model_clear();
    compare();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    compare();
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
    dct_valid = 1'b1;
    dct_buffer = d;
    dct_count = c;
    cycle();
    dct_valid = 1'b0;
  endtask

  initial begin
    logic [LW-1:0] e;

    // Scenario 1: three words in, show-ahead head, in-order drain.
    do_reset();
    chk("reset_fill", 64'(fl0), 64'd0);
    chk("reset_valid", 64'(rv0), 64'd0);
    for (int i = 1; i <= 3; i++) push(DATA_W'(i), CNT_W'(i));
    chk("t1_fill", 64'(fl0), 64'd3);
    chk("t1_valid", 64'(rv0), 64'd1);
    e = {4'd1, 30'h1};
    chk("t1_head", 64'(rd0[LW-1:0]), 64'(e));
    rd_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      e = {CNT_W'(i), DATA_W'(i)};
      chk("t1_order", 64'(rd0[LW-1:0]), 64'(e));
      cycle();
    end
    chk("t1_empty", 64'(fl0), 64'd0);

    // Scenario 2: six words into a 4-deep buffer, both overflow policies.
    do_reset();
    for (int i = 0; i < 6; i++) push(DATA_W'(32'hA + i), 4'd0);
    chk("t2_fill0", 64'(fl0), 64'd4);
    chk("t2_fill1", 64'(fl1), 64'd4);
    chk("t2_ovf0", 64'(ov0), 64'd1);
    chk("t2_ovf1", 64'(ov1), 64'd1);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drop_data", 64'(rd0[DATA_W-1:0]), 64'(32'hA + i));
      chk("t2_wrap_data", 64'(rd1[DATA_W-1:0]), 64'(32'hC + i));
      cycle();
    end

    // Scenario 3: end-of-test with a same-cycle capture, later pushes ignored.
    do_reset();
    push(30'h11, 4'd1);
    push(30'h22, 4'd2);
    dct_valid = 1'b1; dct_buffer = 30'h55; dct_count = 4'd3; test_ending = 1'b1;
    cycle();
    test_ending = 1'b0; dct_buffer = 30'h66; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = (i == 0) ? LW'(30'h11) : (i == 1) ? LW'(30'h22) : LW'(30'h55);
      chk("t3_data", 64'(rd0[DATA_W-1:0]), 64'(e));
      chk("t3_not_ended", 64'(te0), 64'd0);
      cycle();
    end
    chk("t3_ended", 64'(te0), 64'd1);
    test_ending = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_stays_ended", 64'(te0), 64'd1);
    chk("t3_stays_empty", 64'(rv0), 64'd0);
    dct_valid = 1'b0; test_ending = 1'b0;

    // Scenario 4: full push+pop, then reset while draining.
    do_reset();
    for (int i = 0; i < 4; i++) push(DATA_W'(32'h70 + i), 4'd5);
    dct_valid = 1'b1; dct_buffer = 30'h7F; rd_ready = 1'b1;
    cycle();
    chk("t4_fill", 64'(fl0), 64'd4);
    chk("t4_ovf0", 64'(ov0), 64'd0);
    chk("t4_ovf1", 64'(ov1), 64'd0);
    dct_valid = 1'b0; rd_ready = 1'b0; test_ending = 1'b1;
    cycle();
    test_ending = 1'b0;
    cycle();
    do_reset();
    chk("t4_rst_fill", 64'(fl0), 64'd0);
    chk("t4_rst_valid", 64'(rv0), 64'd0);
    chk("t4_rst_ended", 64'(te0), 64'd0);
    push(30'h99, 4'd9);
    chk("t4_capture_again", 64'(fl0), 64'd1);

`ifdef CORE8_OCI_TRACE_TIMESTAMP_EN
    // Timestamp build: pushes at cycles 5 and 9 after reset.
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    push(30'h1, 4'd1);
    for (int i = 0; i < 3; i++) cycle();
    push(30'h2, 4'd1);
    chk("ts_first", 64'(rd0[EW-1 -: 16]), 64'd5);
    rd_ready = 1'b1;
    cycle();
    chk("ts_second", 64'(rd0[EW-1 -: 16]), 64'd9);
    rd_ready = 1'b0;
`endif

    // Randomized traffic with varying consumer pressure.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        dct_valid   = ($urandom_range(0, 2) != 0);
        dct_buffer  = DATA_W'($urandom);
        dct_count   = CNT_W'($urandom);
        rd_ready    = ($urandom_range(0, 3) < r);
        test_ending = ($urandom_range(0, 79) == 0);
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
